// File: rtl/lif_membrane_state.sv
// LIF membrane-potential register stage: leak, threshold, reset, refractory.
// Optional LIF_RESET_BY_SUBTRACTION_EN selects reset-by-subtraction on spike.
module lif_membrane_state #(
  parameter int WIDTH         = 6,
  parameter int REFRACT_WIDTH = 3,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic signed [WIDTH-1:0]  u_bn,
  input  logic signed [WIDTH-1:0]  threshold,
  input  logic [2:0]               leak_shift,
  input  logic [REFRACT_WIDTH-1:0] refractory_period,
  input  logic                     clear_count,
  output logic signed [WIDTH-1:0]  u,
  output logic                     spike,
  output logic                     refractory,
  output logic [COUNT_WIDTH-1:0]   spike_count
);

  logic signed [WIDTH-1:0]  leak;
  logic signed [WIDTH-1:0]  v;
  logic signed [WIDTH-1:0]  u_fire;
  logic [REFRACT_WIDTH-1:0] rcnt;
  logic                     fire;

  always_comb begin
    leak = u_bn >>> leak_shift;
    v    = (leak_shift != 3'd0) ? (u_bn - leak) : u_bn;
    fire = ena && (rcnt == '0) && (v >= threshold);
  end

`ifdef LIF_RESET_BY_SUBTRACTION_EN
  logic signed [WIDTH:0] diff;

  // One extra bit catches overflow; v >= threshold means only +ve overflow
  // is reachable, but both rails are clamped for safety.
  always_comb begin
    diff = {v[WIDTH-1], v} - {threshold[WIDTH-1], threshold};
    if (diff[WIDTH] != diff[WIDTH-1])
      u_fire = diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                           : {1'b0, {(WIDTH-1){1'b1}}};
    else
      u_fire = diff[WIDTH-1:0];
  end
`else
  assign u_fire = '0;
`endif

  assign refractory = (rcnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u     <= '0;
      spike <= 1'b0;
      rcnt  <= '0;
    end else begin
      spike <= fire;
      if (ena) begin
        if (rcnt != '0) begin
          rcnt <= rcnt - 1'b1;
        end else if (fire) begin
          rcnt <= refractory_period;
          u    <= u_fire;
        end else begin
          u    <= v;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      spike_count <= '0;
    else if (clear_count)
      spike_count <= '0;
    else if (fire && (spike_count != '1))
      spike_count <= spike_count + 1'b1;
  end

endmodule

// File: tb/tb_lif_membrane_state.sv
// Bench for lif_membrane_state: vector table plus hand sequences,
// expectations queued on drive and popped after the clock edge.
`timescale 1ns/1ps
module tb_lif_membrane_state;
  localparam int W  = 6;
  localparam int RW = 3;
  localparam int CW = 8;

`ifdef LIF_RESET_BY_SUBTRACTION_EN
  localparam int SUB = 1;
`else
  localparam int SUB = 0;
`endif

  localparam int R1 = SUB ? 2  : 0;
  localparam int R2 = SUB ? 10 : 0;
  localparam int R3 = SUB ? 31 : 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic clear_count = 1'b0;
  logic signed [W-1:0] u_bn = '0;
  logic signed [W-1:0] threshold = '0;
  logic [2:0] leak_shift = '0;
  logic [RW-1:0] refractory_period = '0;
  logic signed [W-1:0] u;
  logic spike;
  logic refractory;
  logic [CW-1:0] spike_count;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int e; int ub; int th; int ls; int rp; int clr;
    int eu; int es; int er; int ec;
  } vec_t;

  typedef struct { int eu; int es; int er; int ec; } exp_t;

  exp_t sb[$];
  vec_t tbl[16];

  lif_membrane_state #(
    .WIDTH(W), .REFRACT_WIDTH(RW), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .u_bn(u_bn),
    .threshold(threshold),
    .leak_shift(leak_shift),
    .refractory_period(refractory_period),
    .clear_count(clear_count),
    .u(u),
    .spike(spike),
    .refractory(refractory),
    .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int e, input int ub, input int th,
                              input int ls, input int rp, input int clr,
                              input int eu, input int es, input int er,
                              input int ec);
    vec_t v;
    v.e = e; v.ub = ub; v.th = th; v.ls = ls; v.rp = rp; v.clr = clr;
    v.eu = eu; v.es = es; v.er = er; v.ec = ec;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    exp_t x;
    exp_t y;
    int su;
    @(negedge clk);
    ena = v.e[0];
    u_bn = W'(v.ub);
    threshold = W'(v.th);
    leak_shift = 3'(v.ls);
    refractory_period = RW'(v.rp);
    clear_count = v.clr[0];
    x.eu = v.eu; x.es = v.es; x.er = v.er; x.ec = v.ec;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_sb: queue empty", tag);
    end else begin
      y = sb.pop_front();
      su = u;
      chk({tag, "_u"}, su, y.eu);
      chk({tag, "_spike"}, int'(spike), y.es);
      chk({tag, "_refr"}, int'(refractory), y.er);
      chk({tag, "_cnt"}, int'(spike_count), y.ec);
    end
  endtask

  initial begin
    tbl[0]  = mk(1,   7,  10, 0, 0, 0,   7, 0, 0, 0);
    tbl[1]  = mk(1,  12,  10, 0, 0, 0,  R1, 1, 0, 1);
    tbl[2]  = mk(1, -13,  10, 2, 0, 0,  -9, 0, 0, 1);
    tbl[3]  = mk(1,  31,  31, 2, 0, 0,  24, 0, 0, 1);
    tbl[4]  = mk(1,  -1,  31, 2, 0, 0,   0, 0, 0, 1);
    tbl[5]  = mk(1, -20,  31, 7, 0, 0, -19, 0, 0, 1);
    tbl[6]  = mk(1, -32,  31, 1, 0, 0, -16, 0, 0, 1);
    tbl[7]  = mk(1,  20,  10, 0, 2, 0,  R2, 1, 1, 2);
    tbl[8]  = mk(1,  20,  10, 0, 2, 0,  R2, 0, 1, 2);
    tbl[9]  = mk(0,   5,  10, 0, 2, 0,  R2, 0, 1, 2);
    tbl[10] = mk(1,  20,  10, 0, 5, 0,  R2, 0, 0, 2);
    tbl[11] = mk(1,  20,  10, 0, 0, 0,  R2, 1, 0, 3);
    tbl[12] = mk(1,  20,  10, 0, 0, 1,  R2, 1, 0, 0);
    tbl[13] = mk(1,  20,  10, 0, 0, 0,  R2, 1, 0, 1);
    tbl[14] = mk(0,  20,  10, 0, 0, 1,  R2, 0, 0, 0);
    tbl[15] = mk(1,  31, -32, 0, 0, 0,  R3, 1, 0, 1);

    #12;
    chk("rst_u", int'(u), 0);
    chk("rst_spike", int'(spike), 0);
    chk("rst_refr", int'(refractory), 0);
    chk("rst_cnt", int'(spike_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++)
      apply(mk(1, 20, 10, 0, 0, 0, R2, 1, 0, i + 1), "pre_rst");
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_u", int'(u), 0);
    chk("async_rst_spike", int'(spike), 0);
    chk("async_rst_refr", int'(refractory), 0);
    chk("async_rst_cnt", int'(spike_count), 0);
    @(negedge clk);
    ena = 1'b0;
    clear_count = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    apply(mk(1, 20, 10, 0, 3, 0, R2, 1, 1, 2), "hold_fire");
    for (int i = 0; i < 5; i++)
      apply(mk(0, int'($urandom_range(63)) - 32, 10, 0, 3, 0, R2, 0, 1, 2),
            "hold_gap");
    apply(mk(1, 20, 10, 0, 3, 0, R2, 0, 1, 2), "drain0");
    apply(mk(1, 20, 10, 0, 3, 0, R2, 0, 1, 2), "drain1");
    apply(mk(1, 20, 10, 0, 3, 0, R2, 0, 0, 2), "drain2");

    apply(mk(0, 0, 10, 0, 0, 1, R2, 0, 0, 0), "sat_clr");
    for (int i = 0; i < 300; i++)
      apply(mk(1, 20, 10, 0, 0, 0, R2, 1, 0, (i + 1 > 255) ? 255 : i + 1),
            "sat");
    apply(mk(1, 20, 10, 0, 0, 1, R2, 1, 0, 0), "sat_clr_fire");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lif_membrane_state.md
# lif_membrane_state

Registered membrane-potential stage of the LIF neuron, directly downstream of `batch_normalization`. Each step:
- takes the normalized potential `u_bn` (the BN block's `u_out`);
- applies shift-based leak;
- compares the leaked value against a threshold and emits a spike;
- applies reset and refractory handling;
- registers the new potential `u`, which feeds back into the BN block's `u` input for the next step.

A saturating spike counter supports readout.

## Interface
Parameters:
- `WIDTH`, 6, membrane/threshold width (signed two's complement); must match the BN block.
- `REFRACT_WIDTH`, 3, refractory counter width.
- `COUNT_WIDTH`, 8, spike counter width.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  step strobe; state advances only on cycles with `ena`=1.
- `u_bn`  in  WIDTH  signed normalized potential from BN stage.
- `threshold`  in  WIDTH  signed spike threshold.
- `leak_shift`  in  3  leak shift amount; 0 = no leak.
- `refractory_period`  in  REFRACT_WIDTH  steps to suppress after a spike.
- `clear_count`  in  1  synchronous clear of spike counter.
- `u`  out  WIDTH  registered membrane potential (to BN `u` input).
- `spike`  out  1  registered one-cycle spike pulse.
- `refractory`  out  1  high while refractory counter ≠ 0.
- `spike_count`  out  COUNT_WIDTH  saturating spike count.

## Operation
- Leak: `leak = u_bn >>> leak_shift` (arithmetic). `v = u_bn - leak` when `leak_shift`≠0, else `v = u_bn`.
  - Shifts ≥1 never increase magnitude, so no saturation is needed.
  - Shift ≥ WIDTH yields `leak` of 0 or -1.
- Step with `ena`=1 and refractory counter = 0:
  - If `v >= threshold` (signed): `spike`←1, refractory counter←`refractory_period`, `u`←reset value (see Configuration).
  - Otherwise: `spike`←0, `u`←`v`.
- Step with `ena`=1 and refractory counter ≠ 0:
  - Counter decrements by 1.
  - `u` is held and `u_bn` is ignored.
  - `spike`←0.
- Cycle with `ena`=0: `u` and the refractory counter hold; `spike`←0.
- `refractory_period` is sampled only on the spiking step. Changing it mid-countdown has no effect. A period of 0 means no refractory.
- `refractory` = (counter ≠ 0), combinational from the register.
- Spike counter:
  - Increments on every cycle where the next `spike` value is 1.
  - Saturates at all-ones.
  - `clear_count`=1 forces it to 0 and takes priority over a simultaneous increment.
  - `clear_count` acts regardless of `ena`.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0):
  - `u`=0, `spike`=0, refractory counter=0 (`refractory`=0), `spike_count`=0.
- Reset asserted mid-operation discards the pending step and any refractory countdown.
- Latency: one clock. `u_bn` sampled on an `ena` edge appears on `u`/`spike` after that edge.
- `spike` is high for exactly one cycle per firing step. Back-to-back firing requires `ena` on consecutive cycles with `refractory_period`=0.
- `u` feeds BN combinationally. There is no combinational path from `u_bn` to any output.

## Configuration
- `LIF_RESET_BY_SUBTRACTION_EN`
  - Defined: on spike, `u`←`v - threshold`, computed in WIDTH+1 bits and saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Undefined: on spike, `u`←0 (reset-to-zero).
- All other behaviour is identical in both builds.

## Test plan
All scenarios use WIDTH=6, REFRACT_WIDTH=3, COUNT_WIDTH=8.

1. **Reset:** drive `u_bn`=20, `threshold`=10, `ena`=1 for 3 cycles, then pull `rst_n` low mid-cycle -> `u`=0, `spike`=0, `refractory`=0, `spike_count`=0 immediately, before the next edge.
2. **Threshold/reset:** `leak_shift`=0, `threshold`=10.
   - `u_bn`=7 -> `u`=7, `spike`=0.
   - Next step `u_bn`=12 -> `spike`=1 for one cycle; `u`=0 without the macro, `u`=2 with it.
3. **Leak:** `leak_shift`=2.
   - `u_bn`=-13 -> `u`=-9.
   - `u_bn`=31 -> `u`=24.
   - `u_bn`=-1 -> `u`=0.
4. **Refractory:** `threshold`=10, `refractory_period`=2, `u_bn`=20 held, `ena`=1 every cycle.
   - Spike on step 1.
   - Steps 2–3: `spike`=0, `refractory`=1, `u` held.
   - Step 4: spike again.
   - `ena`=0 gaps inserted anywhere do not shorten the countdown.
5. **Counter:**
   - 300 firing steps -> `spike_count`=255 (saturated).
   - `clear_count`=1 on the same cycle as a firing step -> `spike_count`=0.
6. **Hold:** `ena`=0 for 5 cycles with varying `u_bn` -> `u` and `refractory` unchanged, `spike`=0.
